// File: rtl/fre_disp_pkg.sv
// Shared types and constants for the frequency-meter display back end.
// Holds the digit count, the converter FSM states and the 7-segment decode table.
// Segment codes are active-low: [0]=a .. [6]=g, [7]=dp (always off).
package fre_disp_pkg;

    localparam int NDIG = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal nibbles cannot occur after a valid conversion; show blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary fre -> 5 packed BCD digits, started when fre changes.
// Ports: clk, rst_n (sync, active-low), fre in; bcd, bcd_valid (1-cycle pulse), busy out.
// Latency: load at E0, bcd/bcd_valid after E0+17; fre changes while busy are picked up on return to IDLE.
module bin2bcd_seq
    import fre_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fre,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] fre_last;
    logic [15:0] shreg;
    logic [19:0] scratch;
    logic [19:0] adj;
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fre != fre_last) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd15)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5 so the following shift carries correctly into the next decade.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < NDIG; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fre_last  <= '0;
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bcd_valid <= 1'b0;
                    if (fre != fre_last) begin
                        shreg    <= fre;
                        fre_last <= fre;
                        scratch  <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {adj, shreg} << 1;
                    cnt              <= cnt + 4'd1;
                end
                DONE: begin
                    // busy stays high through this edge so it covers the cycle bcd_valid is seen.
                    bcd       <= scratch;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fre_disp.sv
// Frequency-meter display: converts fre to BCD and scans it onto a 5-digit common-anode 7-seg display.
// Ports: clk, rst_n (sync, active-low), fre in; bcd, bcd_valid, busy, seg (active-low), sel (active-low one-hot) out.
// Leading zeros are blanked (units always lit); seg/sel are registered, one cycle behind bcd or digit index.
module fre_disp
    import fre_disp_pkg::*;
#(
    parameter int CLK_F   = 50_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fre,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [7:0]  seg,
    output logic [4:0]  sel
);

    localparam int            DIV      = CLK_F / SCAN_HZ;
    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic          tick;
    logic [19:0]   shifted;
    logic          blank;
    logic [7:0]    seg_nxt;
    logic [4:0]    sel_nxt;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .fre       (fre),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    assign tick = (pre == PRE_LAST);

    // Shifting the current digit down to the bottom also exposes all more significant digits,
    // so the blank test is simply "nothing left from this digit upwards".
    always_comb begin
        shifted = bcd >> {idx, 2'b00};
        blank   = (idx != 3'd0) && (shifted == 20'd0);
        seg_nxt = blank ? SEG_BLANK : seg_decode(shifted[3:0]);
        sel_nxt = ~(5'b00001 << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
            sel <= 5'b11110;
            seg <= SEG_0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) idx <= (idx == 3'(NDIG - 1)) ? 3'd0 : idx + 3'd1;
            sel <= sel_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_fre_disp.sv
// Bench for fre_disp: directed scenarios plus random fre/reset traffic, checked every cycle
// against a decimal-arithmetic reference (conversion countdown + scan position from cycle count).
module tb_fre_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fre;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [7:0]  seg;
    logic [4:0]  sel;

    always #5 clk = ~clk;

    // 4 cycles per digit keeps scanning visible in short runs.
    fre_disp #(.CLK_F(4000), .SCAN_HZ(1000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fre       (fre),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .seg       (seg),
        .sel       (sel)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int pow10 [5] = '{1, 10, 100, 1000, 10000};

    int         m_timer;      // cycles until the pending result appears; 0 = converter free
    int         m_last;       // last value taken for conversion
    int         m_conv;       // value being converted
    int         m_val;        // value currently shown
    logic       m_valid;
    logic       m_busy;
    int         m_n;          // clock edges since reset released
    logic [7:0] m_seg;
    logic [4:0] m_sel;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
        return r;
    endfunction

    task automatic model_edge();
        int d;
        int digit;
        if (!rst_n) begin
            m_timer = 0; m_last = 0; m_val = 0; m_valid = 0; m_busy = 0; m_n = 0;
            m_sel = 5'b11110; m_seg = 8'hC0;
        end else begin
            // display registers sample the pre-edge scan position and shown value
            d     = (m_n / 4) % 5;
            digit = (m_val / pow10[d]) % 10;
            m_sel = ~(5'b00001 << d);
            m_seg = (d > 0 && m_val < pow10[d]) ? 8'hFF : seg_tab[digit];
            m_n++;
            if (m_timer == 0) begin
                m_valid = 0;
                if (int'(fre) != m_last) begin
                    m_last = int'(fre); m_conv = int'(fre); m_timer = 17; m_busy = 1;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_val = m_conv; m_valid = 1;
                end
            end
        end
    endtask

    int pulses;
    int busy_cycles;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("bcd",       32'(bcd),       32'(to_bcd(m_val)));
            check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
            check("busy",      32'(busy),      32'(m_busy));
            check("seg",       32'(seg),       32'(m_seg));
            check("sel",       32'(sel),       32'(m_sel));
            if (bcd_valid) pulses++;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fre   = 16'd0;
        step(2);
        rst_n = 1'b1;

        // fre=0 after reset: no conversion, units lit, upper digits blank
        pulses = 0;
        step(100);
        check("no_pulse_after_reset", 32'(pulses), 32'd0);

        // 12345: single pulse, busy for 18 cycles
        pulses = 0; busy_cycles = 0;
        fre = 16'd12345;
        step(1);
        check("busy_at_E0", 32'(busy), 32'd1);
        step(16);
        check("no_valid_E0p16", 32'(bcd_valid), 32'd0);
        step(1);
        check("valid_E0p17", 32'(bcd_valid), 32'd1);
        check("bcd_12345", 32'(bcd), 32'h12345);
        step(1);
        check("busy_low_E0p18", 32'(busy), 32'd0);
        step(10);
        check("pulses_12345", 32'(pulses), 32'd1);
        check("busy_len_12345", 32'(busy_cycles), 32'd18);

        // max value then zero
        fre = 16'd65535;
        step(25);
        check("bcd_65535", 32'(bcd), 32'h65535);
        fre = 16'd0;
        step(45);
        check("bcd_zero", 32'(bcd), 32'h0);

        // value change during SHIFT is deferred, both get converted
        pulses = 0;
        fre = 16'd100;
        step(6);
        fre = 16'd200;
        step(20);
        check("bcd_100_then", 32'(bcd), 32'h00100);
        step(25);
        check("bcd_200", 32'(bcd), 32'h00200);
        check("pulses_100_200", 32'(pulses), 32'd2);

        // single digit, watch full scan wrap
        fre = 16'd7;
        step(45);

        // reset during SHIFT aborts, same value reconverted after release
        pulses = 0;
        fre = 16'd4321;
        step(9);
        rst_n = 1'b0;
        step(1);
        check("busy_after_abort", 32'(busy), 32'd0);
        check("bcd_after_abort", 32'(bcd), 32'd0);
        rst_n = 1'b1;
        step(25);
        check("bcd_reconv", 32'(bcd), 32'h04321);
        check("pulses_reconv", 32'(pulses), 32'd1);

        // random traffic
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 3))
                0:       fre = 16'($urandom_range(0, 9));
                1:       fre = 16'($urandom_range(0, 999));
                default: fre = 16'($urandom_range(0, 65535));
            endcase
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step($urandom_range(1, 25));
        end
        step(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
